fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-sequencing stage that drives the instruction-memory address and feeds the decode stage. Holds the PC, the data-memory page register and the branch-bank register, and applies the page/bank adjust strobes and branch requests that decode produces each cycle. Runs an IDLE/RUN/DONE sequence and drives the `init` qualifier that forces decode to emit an all-zero control word while the core is not running.

## Interface
Parameters:
- `PC_W`, 10, PC width; instruction memory depth 2^PC_W
- `PROG_LEN`, 1024, number of program words; last executable address is `PROG_LEN-1`
- `PAGE_W`, 3, page register width
- `BANK_W`, 2, branch-bank register width
- `IDX_W`, 4, branch index field width (`instruction[IDX_W-1:0]`)
- `CNT_W`, 16, cycle counter width

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin program execution (sampled in IDLE and DONE)
- `branch` in 1: branch request from decode (`ctrl.branch`)
- `branch_cond` in 1: condition flag from ALU; branch taken when `branch && branch_cond`
- `br_idx` in IDX_W: branch index field from current instruction
- `inc_page`, `dec_page` in 1: page adjust strobes from decode
- `inc_bank`, `dec_bank` in 1: bank adjust strobes from decode (`incrementBranch`/`decrementBranch`)
- `pc` out PC_W: instruction-memory address
- `page` out PAGE_W: data-memory page
- `bank` out BANK_W: current branch bank
- `init` out 1: high when state != RUN; feeds decode `init`
- `done` out 1: high in DONE
- `cycles` out CNT_W: instructions executed in current/last run

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0 except `init`=1.
- IDLE: `start`=1 → RUN next edge; `pc`, `page`, `bank`, `cycles` cleared to 0 on that edge.
- RUN, per cycle (all strobes ignored outside RUN):
  - taken = `branch && branch_cond`; taken → `pc` ← `branch_lut[{bank, br_idx}]`; else `pc` ← `pc+1`.
  - not taken and `pc == PROG_LEN-1` → DONE next edge; `pc` holds.
  - taken at `pc == PROG_LEN-1` → jump, stay in RUN.
  - `page` ← `page±1` modulo 2^PAGE_W (wrap, 7+1=0, 0-1=7); inc and dec together → hold.
  - `bank` same rule, modulo 2^BANK_W.
  - Lookup uses `bank` value before any same-cycle bank update.
  - `cycles` increments each RUN cycle, saturates at all-ones.
- DONE: `pc`, `page`, `bank`, `cycles` hold; `start`=1 → RUN with same clearing as from IDLE.
- `start` in RUN ignored. `reset` at any time → IDLE next edge, overriding all else.

## Timing
- Single-cycle core: decode/ALU combinational from `pc`; every RUN edge retires one instruction.
- `pc`, `page`, `bank` change only on the edge ending the instruction that requested the change; the next instruction sees new values.
- `init` falls on the edge entering RUN; first instruction (address 0) executes in that cycle.
- `done` rises on the edge after the final instruction; `init` rises on the same edge.
- No combinational path from any input to any output except through `branch_lut` into next-state logic.

## Structure
- Shared package: state enum `seq_state_t` {IDLE, RUN, DONE}; branch-LUT contents constant; HALT address derived from `PROG_LEN`.
- One sub-module: `branch_lut`, combinational ROM, 2^(BANK_W+IDX_W) entries × PC_W, indexed by `{bank, br_idx}`.

## Test plan
- Reset then `start` pulse, no branches, PROG_LEN=8: `pc` 0..7 over 8 cycles, `done`=1 after 8th edge, `cycles`=8, `init` 1→0→1.
- Branch at pc=3, bank=0, br_idx=2, LUT[2]=0x10, cond=1 → `pc`=0x10 next; cond=0 → `pc`=4.
- `inc_bank` at pc=1 then branch at pc=2 with br_idx=2 → target LUT[{1,2}]=LUT[18]; bank change and branch in same cycle use old bank.
- `page`=7 + `inc_page` → 0; `page`=0 + `dec_page` → 7; `inc_page` and `dec_page` together → unchanged; strobes in IDLE ignored.
- Taken branch at pc=PROG_LEN-1 → jumps, no DONE; subsequent fall-through at last address → DONE.
- `reset` asserted mid-RUN at pc=5, page=3 → next edge IDLE, all outputs 0, `init`=1; `start` in DONE restarts from pc=0, `cycles`=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer_pkg
// Purpose  : Shared definitions for the fetch sequencer: sequencer state
//            encoding, branch-target ROM contents and the HALT address rule.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Branch targets are laid out on an 8-word stride: entry N jumps to 8*N.
  // Entry 0 therefore always returns to the program start.
  localparam int unsigned LUT_STRIDE = 8;

  function automatic logic [31:0] lut_entry(input int unsigned idx);
    return 32'(idx * LUT_STRIDE);
  endfunction

  // Last executable program address; fall-through from here ends the run.
  function automatic int unsigned halt_addr(input int unsigned prog_len);
    return prog_len - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_branch_lut.sv
`default_nettype none
// ============================================================================
// Module   : branch_lut
// Purpose  : Combinational branch-target ROM, 2^(BANK_W+IDX_W) entries of
//            PC_W bits, indexed by {bank, br_idx}.
// Ports    : idx    in  BANK_W+IDX_W : ROM address {bank, br_idx}
//            target out PC_W         : branch target address
// Revision : 1.0 - initial release
// ============================================================================
module branch_lut
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int BANK_W = 2,
  parameter int IDX_W  = 4
) (
  input  logic [BANK_W+IDX_W-1:0] idx,
  output logic [PC_W-1:0]         target
);

  localparam int DEPTH = 1 << (BANK_W + IDX_W);

  logic [PC_W-1:0] w_rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [31:0]     C_FULL = lut_entry(i);
    localparam logic [PC_W-1:0] C_VAL  = C_FULL[PC_W-1:0];
    assign w_rom[i] = C_VAL;
  end

  assign target = w_rom[idx];

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Program sequencer for a single-cycle core. Holds PC, data page
//            and branch bank; applies decode strobes and branches while
//            running; runs an IDLE/RUN/DONE sequence.
// Ports    : clk, reset (sync, active-high)
//            start                     : begin a run (IDLE/DONE only)
//            branch, branch_cond       : branch taken when both high
//            br_idx [IDX_W]            : branch index of current instruction
//            inc_page, dec_page        : page adjust strobes
//            inc_bank, dec_bank        : bank adjust strobes
//            pc [PC_W]                 : instruction memory address
//            page [PAGE_W], bank [BANK_W]
//            init                      : high whenever not in RUN
//            done                      : high in DONE
//            cycles [CNT_W]            : instructions retired this run
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int PROG_LEN = 1024,
  parameter int PAGE_W   = 3,
  parameter int BANK_W   = 2,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              branch,
  input  logic              branch_cond,
  input  logic [IDX_W-1:0]  br_idx,
  input  logic              inc_page,
  input  logic              dec_page,
  input  logic              inc_bank,
  input  logic              dec_bank,
  output logic [PC_W-1:0]   pc,
  output logic [PAGE_W-1:0] page,
  output logic [BANK_W-1:0] bank,
  output logic              init,
  output logic              done,
  output logic [CNT_W-1:0]  cycles
);

  localparam logic [PC_W-1:0] C_HALT = PC_W'(halt_addr(PROG_LEN));

  seq_state_t        r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [PAGE_W-1:0] r_page, w_page_nxt;
  logic [BANK_W-1:0] r_bank, w_bank_nxt;
  logic [CNT_W-1:0]  r_cycles, w_cycles_nxt;
  logic [PC_W-1:0]   w_target;
  logic              w_taken;

  // Lookup is addressed with the registered bank, so a bank strobe in the
  // same cycle as a branch only affects the following instruction.
  branch_lut #(
    .PC_W   (PC_W),
    .BANK_W (BANK_W),
    .IDX_W  (IDX_W)
  ) u_branch_lut (
    .idx    ({r_bank, br_idx}),
    .target (w_target)
  );

  assign w_taken = branch && branch_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_page   <= '0;
      r_bank   <= '0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_page   <= w_page_nxt;
      r_bank   <= w_bank_nxt;
      r_cycles <= w_cycles_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_page_nxt   = r_page;
    w_bank_nxt   = r_bank;
    w_cycles_nxt = r_cycles;
    case (r_state)
      RUN: begin
        if (w_taken) begin
          w_pc_nxt = w_target;
        end else if (r_pc == C_HALT) begin
          w_state_nxt = DONE;
        end else begin
          w_pc_nxt = r_pc + 1'b1;
        end
        // Opposing strobes cancel; modular arithmetic gives the wrap.
        if (inc_page && !dec_page) w_page_nxt = r_page + 1'b1;
        if (dec_page && !inc_page) w_page_nxt = r_page - 1'b1;
        if (inc_bank && !dec_bank) w_bank_nxt = r_bank + 1'b1;
        if (dec_bank && !inc_bank) w_bank_nxt = r_bank - 1'b1;
        if (r_cycles != {CNT_W{1'b1}}) w_cycles_nxt = r_cycles + 1'b1;
      end
      default: begin
        // IDLE and DONE: only start matters, and it begins a fresh run.
        if (start) begin
          w_state_nxt  = RUN;
          w_pc_nxt     = '0;
          w_page_nxt   = '0;
          w_bank_nxt   = '0;
          w_cycles_nxt = '0;
        end
      end
    endcase
  end

  assign pc     = r_pc;
  assign page   = r_page;
  assign bank   = r_bank;
  assign cycles = r_cycles;
  assign init   = (r_state != RUN);
  assign done   = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed self-checking bench for fetch_sequencer (PROG_LEN=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int PC_W = 10, PROG_LEN = 8, PAGE_W = 3, BANK_W = 2,
                 IDX_W = 4, CNT_W = 16;

  logic              clk = 1'b0;
  logic              reset, start, branch, branch_cond;
  logic [IDX_W-1:0]  br_idx;
  logic              inc_page, dec_page, inc_bank, dec_bank;
  logic [PC_W-1:0]   pc;
  logic [PAGE_W-1:0] page;
  logic [BANK_W-1:0] bank;
  logic              init, done;
  logic [CNT_W-1:0]  cycles;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_sequencer #(
    .PC_W(PC_W), .PROG_LEN(PROG_LEN), .PAGE_W(PAGE_W),
    .BANK_W(BANK_W), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .branch(branch),
    .branch_cond(branch_cond), .br_idx(br_idx),
    .inc_page(inc_page), .dec_page(dec_page),
    .inc_bank(inc_bank), .dec_bank(dec_bank),
    .pc(pc), .page(page), .bank(bank), .init(init), .done(done),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    start = 0; branch = 0; branch_cond = 0; br_idx = '0;
    inc_page = 0; dec_page = 0; inc_bank = 0; dec_bank = 0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc,
                         input logic [31:0] e_page, input logic [31:0] e_bank,
                         input logic e_init, input logic e_done,
                         input logic [31:0] e_cyc);
    chk({tag, ".pc"},     32'(pc),     e_pc);
    chk({tag, ".page"},   32'(page),   e_page);
    chk({tag, ".bank"},   32'(bank),   e_bank);
    chk({tag, ".init"},   32'(init),   32'(e_init));
    chk({tag, ".done"},   32'(done),   32'(e_done));
    chk({tag, ".cycles"}, 32'(cycles), e_cyc);
  endtask

  initial begin
    clr_in();
    reset = 1;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 1, 0, 0);
    reset = 0;

    // Straight-line run over all 8 words
    start = 1; tick(); start = 0;
    chk_all("run_enter", 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("seq.pc", 32'(pc), 32'(i));
      chk("seq.cycles", 32'(cycles), 32'(i));
    end
    tick();
    chk_all("seq_done", 7, 0, 0, 1, 1, 8);

    // Strobes and branches in DONE are ignored
    inc_page = 1; inc_bank = 1; branch = 1; branch_cond = 1; br_idx = 4'd2;
    tick(); clr_in();
    chk_all("done_hold", 7, 0, 0, 1, 1, 8);

    // Restart from DONE; branch sequences
    start = 1; tick(); start = 0;
    chk_all("restart", 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("pc3", 32'(pc), 3);
    branch = 1; branch_cond = 0; br_idx = 4'd2; tick();
    chk("br_nt.pc", 32'(pc), 4);
    branch_cond = 1; br_idx = 4'd0; tick();
    chk("br_idx0.pc", 32'(pc), 0);
    branch = 0; tick(); tick(); tick();
    branch = 1; br_idx = 4'd2; tick();
    chk("br_lut2.pc", 32'(pc), 32'h10);
    br_idx = 4'd0; tick(); clr_in();
    chk("br_back.pc", 32'(pc), 0);
    tick();
    inc_bank = 1; tick(); clr_in();
    chk("inc_bank.bank", 32'(bank), 1);
    chk("inc_bank.pc", 32'(pc), 2);
    // Branch with a same-cycle bank decrement: lookup uses bank 1
    branch = 1; branch_cond = 1; br_idx = 4'd2; dec_bank = 1; tick();
    chk("br_oldbank.pc", 32'(pc), 32'h90);
    chk("br_oldbank.bank", 32'(bank), 0);
    dec_bank = 0; br_idx = 4'd0; tick(); clr_in();
    chk("br_home.pc", 32'(pc), 0);

    // Page / bank wrap and cancel
    dec_page = 1; tick(); clr_in();
    chk("page_dec_wrap", 32'(page), 7);
    inc_page = 1; tick(); clr_in();
    chk("page_inc_wrap", 32'(page), 0);
    inc_page = 1; dec_page = 1; tick(); clr_in();
    chk("page_both", 32'(page), 0);
    chk("page_both.pc", 32'(pc), 3);
    dec_bank = 1; tick(); clr_in();
    chk("bank_dec_wrap", 32'(bank), 3);
    inc_bank = 1; tick(); clr_in();
    chk("bank_inc_wrap", 32'(bank), 0);
    tick(); tick();
    chk("pc_last", 32'(pc), 7);

    // Taken branch at the last address keeps running
    branch = 1; branch_cond = 1; br_idx = 4'd0; tick(); clr_in();
    chk_all("br_at_halt", 0, 0, 0, 0, 0, 22);
    for (int i = 0; i < 7; i++) tick();
    chk("pc_last2", 32'(pc), 7);
    tick();
    chk_all("halt_done", 7, 0, 0, 1, 1, 30);

    // Restart, start in RUN ignored, reset mid-run
    start = 1; tick(); start = 0;
    chk_all("restart2", 0, 0, 0, 0, 0, 0);
    inc_page = 1; tick(); tick(); tick(); clr_in();
    chk("page3", 32'(page), 3);
    start = 1; tick(); start = 0;
    chk("start_in_run.pc", 32'(pc), 4);
    tick();
    chk_all("pre_reset", 5, 3, 0, 0, 0, 5);
    reset = 1; tick(); reset = 0;
    chk_all("mid_reset", 0, 0, 0, 1, 0, 0);

    // Strobes in IDLE ignored
    inc_page = 1; inc_bank = 1; branch = 1; branch_cond = 1; br_idx = 4'd3;
    tick(); clr_in();
    chk_all("idle_hold", 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
